fd_queue_latch: RTL and testbench
=================================

Name: fd_queue_latch

Overview:
Parametrised successor to the single-entry fetch/decode pipeline latch: a DEPTH-entry instruction queue between fetch and decode with a valid/ready handshake, flush and bubble insertion. Each entry holds a 32-bit instruction plus its sequential next PC. The head entry is split into the fixed ISA decode fields. Fetch can run ahead of a stalled decode stage by up to DEPTH instructions, and a taken branch or jump clears all in-flight fetches in one cycle.

Parameters:
PC_W, 12, width of the sequential next-PC field carried with each instruction
DEPTH, 2, number of queue entries; legal range 1..16, any integer (not restricted to a power of two)
CNT_W, 5, width of the occupancy count; must satisfy 2^CNT_W > DEPTH

Ports:
clock  in  1  rising-edge system clock
reset  in  1  asynchronous, active-high reset
inst  in  32  fetched instruction
seqNextPcIn  in  PC_W  PC+1 of the fetched instruction
inValid  in  1  fetch presents a valid instruction this cycle
inReady  out  1  queue can accept a push this cycle
outReady  in  1  decode consumes the head entry this cycle (not asserted while decode stalls)
flush  in  1  discard all entries (taken branch or jump)
outValid  out  1  head entry is valid
opcode  out  5  head instruction [31:27]
rd  out  5  head instruction [26:22]
rs  out  5  head instruction [21:17]
rt  out  5  head instruction [16:12]
shamt  out  5  head instruction [11:7]
aluOp  out  5  head instruction [6:2]
imm  out  17  head instruction [16:0]
t  out  27  head instruction [26:0]
seqNextPcOut  out  PC_W  next PC of the head entry
count  out  CNT_W  current occupancy, 0..DEPTH

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation): pointers = 0, count = 0, outValid = 0, all storage cleared. All decode outputs and seqNextPcOut read 0. inReady = 1.
- Push: occurs when inValid && inReady at the clock edge. Writes {inst, seqNextPcIn} at the tail; the tail wraps from DEPTH-1 to 0.
- Pop: occurs when outValid && outReady at the clock edge. The head advances and wraps from DEPTH-1 to 0.
- inReady = (count < DEPTH). It is registered-state only, with no combinational path from outReady, so a full queue does not accept a push even in a cycle where a pop occurs.
- Simultaneous push and pop (count not full): count is unchanged and both pointers advance.
- outValid = (count != 0). Base latency is 1 cycle: an instruction pushed at edge N is visible on the outputs after edge N.
- Bubble: when outValid = 0, every decode output and seqNextPcOut is forced to 0. The all-zero word is a nop in the ISA, so decode and execute need no separate valid gating.
- Flush: has priority over push and pop in the same cycle; any push in that cycle is dropped. After the edge, count = 0, pointers = 0 and outputs show the bubble.
- Pop with count = 0 is ignored. Push with inReady = 0 is ignored, and fetch must hold inst until accepted.
- count updates by +1, -1 or 0 per edge and never exceeds DEPTH or underflows.
- DEPTH = 1 must give the same timing as the original single latch when outReady = 1 every cycle. Note that throughput is then one instruction every 2 cycles, because inReady is 0 while the single entry is occupied.

Optional Feature:
FDQ_BYPASS_EN
- Defined: when count = 0, inValid = 1 and flush = 0, inst and seqNextPcIn drive the outputs combinationally with outValid = 1. If outReady is also 1, the instruction is consumed with 0 latency and never written into the queue.
- Not defined: no bypass; minimum latency is 1 cycle, and there is no combinational path from the inputs to the outputs.

Test Plan:
- Reset during traffic (count = 2) -> outputs 0, count = 0 and inReady = 1 immediately, without waiting for a clock edge.
- Push inst 0x2A4C3E1C with seqNextPcIn 0x005, outReady = 1 -> next cycle: opcode 0x05, rd 0x09, rs 0x06, rt 0x03, shamt 0x1C, aluOp 0x07, imm 0x03E1C, t 0x24C3E1C, seqNextPcOut 0x005.
- DEPTH = 2 with outReady = 0: push A, B, then C -> count = 2, inReady = 0, C not accepted. Then outReady = 1 -> A, then B, then C are delivered in order with correct PCs across pointer wrap.
- Simultaneous push and pop with count = 1 for 10 cycles -> count stays 1 and the output sequence matches the input sequence delayed by 1 entry.
- Flush asserted together with inValid while count = 2 -> next cycle count = 0, outValid = 0, all fields 0, and the concurrent push is dropped.
- Build with FDQ_BYPASS_EN, queue empty, inValid = 1, outReady = 1 -> the same-cycle output equals the input fields and count stays 0.
- Build without FDQ_BYPASS_EN, same stimulus -> output appears 1 cycle later.

Source files
------------

// File: rtl/fd_queue_latch.sv
// Fetch/decode instruction queue: DEPTH entries of {inst, next PC}, head split into decode fields.
// Optional FDQ_BYPASS_EN: empty queue forwards the fetched instruction combinationally.
module fd_queue_latch #(
  parameter int PC_W  = 12,
  parameter int DEPTH = 2,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      inst,
  input  logic [PC_W-1:0]  seqNextPcIn,
  input  logic             inValid,
  output logic             inReady,
  input  logic             outReady,
  input  logic             flush,
  output logic             outValid,
  output logic [4:0]       opcode,
  output logic [4:0]       rd,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       shamt,
  output logic [4:0]       aluOp,
  output logic [16:0]      imm,
  output logic [26:0]      t,
  output logic [PC_W-1:0]  seqNextPcOut,
  output logic [CNT_W-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [31:0]      qinst [DEPTH];
  logic [PC_W-1:0]  qpc   [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CNT_W-1:0] cnt;
  logic             push;
  logic             pop;
  logic             bypass;
  logic [31:0]      word;
  logic [PC_W-1:0]  pcw;

  // inReady depends only on stored occupancy, never on outReady
  assign inReady = (cnt < FULL);
  assign count   = cnt;

  // handshake decisions and bubble-gated head selection
  always_comb begin
    bypass = 1'b0;
`ifdef FDQ_BYPASS_EN
    bypass = (cnt == '0) && inValid && !flush;
`endif
    outValid = (cnt != '0) || bypass;
    push = inValid && inReady && !flush && !(bypass && outReady);
    pop  = (cnt != '0) && outReady && !flush;
    word = '0;
    pcw  = '0;
    if (bypass) begin
      word = inst;
      pcw  = seqNextPcIn;
    end else if (cnt != '0) begin
      word = qinst[head];
      pcw  = qpc[head];
    end
  end

  assign opcode       = word[31:27];
  assign rd           = word[26:22];
  assign rs           = word[21:17];
  assign rt           = word[16:12];
  assign shamt        = word[11:7];
  assign aluOp        = word[6:2];
  assign imm          = word[16:0];
  assign t            = word[26:0];
  assign seqNextPcOut = pcw;

  // storage, wrapping pointers and occupancy; flush wins over push/pop
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        qinst[i] <= '0;
        qpc[i]   <= '0;
      end
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        qinst[tail] <= inst;
        qpc[tail]   <= seqNextPcIn;
        tail <= (tail == LAST) ? '0 : tail + PW'(1);
      end
      if (pop)
        head <= (head == LAST) ? '0 : head + PW'(1);
      if (push && !pop)
        cnt <= cnt + CNT_W'(1);
      else if (pop && !push)
        cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fd_queue_latch.sv
// Scoreboard bench for fd_queue_latch (DEPTH=2, PC_W=12).
// Expected entries are queued at accepted pushes and compared at each sample.
module tb_fd_queue_latch;

  localparam int PC_W  = 12;
  localparam int DEPTH = 2;
  localparam int CNT_W = 5;

  logic             clock = 1'b0;
  logic             reset;
  logic [31:0]      inst;
  logic [PC_W-1:0]  seqNextPcIn;
  logic             inValid;
  logic             inReady;
  logic             outReady;
  logic             flush;
  logic             outValid;
  logic [4:0]       opcode, rd, rs, rt, shamt, aluOp;
  logic [16:0]      imm;
  logic [26:0]      t;
  logic [PC_W-1:0]  seqNextPcOut;
  logic [CNT_W-1:0] count;

  int nchk  = 0;
  int nfail = 0;
  int mcnt  = 0;
  logic [43:0] sb [$];

  fd_queue_latch #(.PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .inst(inst), .seqNextPcIn(seqNextPcIn),
    .inValid(inValid), .inReady(inReady), .outReady(outReady), .flush(flush),
    .outValid(outValid), .opcode(opcode), .rd(rd), .rs(rs), .rt(rt),
    .shamt(shamt), .aluOp(aluOp), .imm(imm), .t(t),
    .seqNextPcOut(seqNextPcOut), .count(count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_fields(input string tag, input logic [31:0] w,
                            input logic [PC_W-1:0] p);
    check({tag, ".opcode"}, 64'(opcode), 64'(w[31:27]));
    check({tag, ".rd"},     64'(rd),     64'(w[26:22]));
    check({tag, ".rs"},     64'(rs),     64'(w[21:17]));
    check({tag, ".rt"},     64'(rt),     64'(w[16:12]));
    check({tag, ".shamt"},  64'(shamt),  64'(w[11:7]));
    check({tag, ".aluop"},  64'(aluOp),  64'(w[6:2]));
    check({tag, ".imm"},    64'(imm),    64'(w[16:0]));
    check({tag, ".t"},      64'(t),      64'(w[26:0]));
    check({tag, ".pc"},     64'(seqNextPcOut), 64'(p));
  endtask

  // hand-decoded fields of 0x2A4C3E1C / 0x005
  task automatic chk_known();
    check("k.opcode", 64'(opcode), 64'h05);
    check("k.rd",     64'(rd),     64'h09);
    check("k.rs",     64'(rs),     64'h06);
    check("k.rt",     64'(rt),     64'h03);
    check("k.shamt",  64'(shamt),  64'h1C);
    check("k.aluop",  64'(aluOp),  64'h07);
    check("k.imm",    64'(imm),    64'h03E1C);
    check("k.t",      64'(t),      64'h24C3E1C);
    check("k.pc",     64'(seqNextPcOut), 64'h005);
  endtask

  // sample at negedge against the model, then advance the model past posedge
  task automatic cyc(input string tag);
    logic        mov, byp, push, pop;
    logic [43:0] e;
    @(negedge clock);
    byp = 1'b0;
    mov = (mcnt != 0);
`ifdef FDQ_BYPASS_EN
    if (mcnt == 0 && inValid && !flush) begin
      byp = 1'b1;
      mov = 1'b1;
    end
`endif
    e = '0;
    if (byp) e = {inst, seqNextPcIn};
    else if (mcnt != 0) e = sb[0];
    check({tag, ".ovalid"}, 64'(outValid), 64'(mov));
    check({tag, ".count"},  64'(count),    64'(mcnt));
    check({tag, ".irdy"},   64'(inReady),  64'(mcnt < DEPTH));
    chk_fields(tag, e[43:12], e[11:0]);
    push = inValid && (mcnt < DEPTH) && !flush && !(byp && outReady);
    pop  = (mcnt != 0) && outReady && !flush;
    @(posedge clock);
    #1;
    if (flush) begin
      sb.delete();
      mcnt = 0;
    end else begin
      if (pop) begin
        void'(sb.pop_front());
        mcnt--;
      end
      if (push) begin
        sb.push_back({inst, seqNextPcIn});
        mcnt++;
      end
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] i,
                       input logic [PC_W-1:0] p, input logic r);
    inValid = v;
    inst = i;
    seqNextPcIn = p;
    outReady = r;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    drive(1'b0, 32'h0, '0, 1'b0);
    #3;
    check("rst.count", 64'(count), 64'd0);
    check("rst.irdy",  64'(inReady), 64'd1);
    check("rst.ovalid", 64'(outValid), 64'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // known decode word
    drive(1'b1, 32'h2A4C3E1C, 12'h005, 1'b1);
`ifdef FDQ_BYPASS_EN
    #1 chk_known();
`endif
    cyc("k0");
    inValid = 1'b0;
`ifndef FDQ_BYPASS_EN
    #1 chk_known();
`endif
    cyc("k1");
    cyc("k2");

    // fill with decode stalled, C refused, then drain in order across wrap
    drive(1'b1, 32'hA0000001, 12'h101, 1'b0); cyc("fa");
    drive(1'b1, 32'hB0000002, 12'h102, 1'b0); cyc("fb");
    drive(1'b1, 32'hC0000003, 12'h103, 1'b0); cyc("fc0");
    cyc("fc1");
    outReady = 1'b1;
    cyc("d0");
    cyc("d1");
    inValid = 1'b0;
    cyc("d2");
    cyc("d3");

    // steady push+pop at count 1
    drive(1'b1, 32'h11111111, 12'h200, 1'b0); cyc("s0");
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, $urandom, 12'(12'h201 + i), 1'b1);
      cyc("ss");
      check("ss.cnt1", 64'(count), 64'd1);
    end
    inValid = 1'b0;
    cyc("s1");
    cyc("s2");

    // flush with concurrent push while full
    drive(1'b1, 32'h0F0F0F0F, 12'h301, 1'b0); cyc("fl0");
    drive(1'b1, 32'h1E1E1E1E, 12'h302, 1'b0); cyc("fl1");
    drive(1'b1, 32'h2D2D2D2D, 12'h303, 1'b1);
    flush = 1'b1;
    cyc("fl2");
    flush = 1'b0;
    inValid = 1'b0;
    cyc("fl3");
    check("fl.ovalid", 64'(outValid), 64'd0);
    check("fl.count",  64'(count), 64'd0);

    // asynchronous reset mid-traffic at count 2
    drive(1'b1, 32'h3C3C3C3C, 12'h401, 1'b0); cyc("r0");
    drive(1'b1, 32'h4B4B4B4B, 12'h402, 1'b0); cyc("r1");
    inValid = 1'b0;
    check("r.pre", 64'(count), 64'd2);
    #1 reset = 1'b1;
    #1;
    check("ra.count",  64'(count), 64'd0);
    check("ra.irdy",   64'(inReady), 64'd1);
    check("ra.ovalid", 64'(outValid), 64'd0);
    check("ra.opcode", 64'(opcode), 64'd0);
    check("ra.t",      64'(t), 64'd0);
    check("ra.pc",     64'(seqNextPcOut), 64'd0);
    #1 reset = 1'b0;
    sb.delete();
    mcnt = 0;
    cyc("r2");

    // random traffic
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, 12'($urandom),
            $urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 19) == 0);
      cyc("rnd");
    end
    flush = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
